// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX/MEM and MEM/WB.
// Issues one load/store at a time on a req/ack data bus and stalls the pipeline
// until the access completes. It also aligns and extends load data, flags
// address errors, and produces the write-back triple.
//
// Optional feature macro: MEM_LWLR_EN. When it is defined, LWL/LWR/SWL/SWR are
// supported. When it is not defined, those four ops are no-ops: no bus access,
// no stall, no write-back and no exception.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   flush                     discard the instruction in MEM
//   mem_pc, mem_aluop         PC and operation of the instruction in MEM
//   mem_alures, mem_opr2      ALU result, old rt value (merge source for LWL/LWR)
//   mem_wreg, mem_wraddr      register write enable / address
//   mem_m_en, mem_m_wen       access request, store byte lanes
//   mem_m_vaddr, mem_m_wdata  access address, lane-positioned store data
//   dbus_*                    data bus: req/addr/wen/wdata out, rdata/ack in
//   stall_req                 freeze IF..EX/MEM
//   exc_adel/ades/badvaddr    load/store address error and faulting address
//   wb_pc/wreg/wraddr/wrdata  to MEM/WB register
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] mem_pc,
   input  logic [7:0]  mem_aluop,
   input  logic [31:0] mem_alures,
   input  logic [31:0] mem_opr2,
   input  logic        mem_wreg,
   input  logic [4:0]  mem_wraddr,
   input  logic        mem_m_en,
   input  logic [3:0]  mem_m_wen,
   input  logic [31:0] mem_m_vaddr,
   input  logic [31:0] mem_m_wdata,
   output logic        dbus_req,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_wen,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic        stall_req,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic [31:0] exc_badvaddr,
   output logic [31:0] wb_pc,
   output logic        wb_wreg,
   output logic [4:0]  wb_wraddr,
   output logic [31:0] wb_wrdata
);

   localparam logic [7:0] ALU_LB  = 8'h10, ALU_LBU = 8'h11, ALU_LH  = 8'h12, ALU_LHU = 8'h13;
   localparam logic [7:0] ALU_LW  = 8'h14, ALU_LWL = 8'h15, ALU_LWR = 8'h16;
   localparam logic [7:0] ALU_SB  = 8'h18, ALU_SH  = 8'h19, ALU_SW  = 8'h1A;
   localparam logic [7:0] ALU_SWL = 8'h1B, ALU_SWR = 8'h1C;

`ifdef MEM_LWLR_EN
   localparam bit LwlrEn = 1'b1;
`else
   localparam bit LwlrEn = 1'b0;
   logic unused_opr2;
   assign unused_opr2 = ^mem_opr2;
`endif

   typedef enum logic [1:0] {StIdle, StReq, StDone, StAbort} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  wen_q;
   logic        latch, capture;

   logic        is_load, is_store, is_half, is_word, is_lwlr;
   logic        op_off, addr_err, access_ok;
   logic [1:0]  b;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   // Operation decode
   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_half  = 1'b0;
      is_word  = 1'b0;
      is_lwlr  = 1'b0;
      case (mem_aluop)
         ALU_LB, ALU_LBU:  is_load = 1'b1;
         ALU_LH, ALU_LHU:  begin is_load = 1'b1;  is_half = 1'b1; end
         ALU_LW:           begin is_load = 1'b1;  is_word = 1'b1; end
         ALU_LWL, ALU_LWR: begin is_load = 1'b1;  is_lwlr = 1'b1; end
         ALU_SB:           is_store = 1'b1;
         ALU_SH:           begin is_store = 1'b1; is_half = 1'b1; end
         ALU_SW:           begin is_store = 1'b1; is_word = 1'b1; end
         ALU_SWL, ALU_SWR: begin is_store = 1'b1; is_lwlr = 1'b1; end
         default: ;
      endcase
   end

   // Unaligned ops behave as plain no-ops when the feature is compiled out
   assign op_off    = is_lwlr & ~LwlrEn;
   assign b         = mem_m_vaddr[1:0];
   assign addr_err  = mem_m_en & ~op_off &
                      ((is_half & b[0]) | (is_word & (b != 2'b00)));
   assign access_ok = mem_m_en & ~addr_err & ~flush & ~op_off;

   assign exc_adel     = addr_err & is_load;
   assign exc_ades     = addr_err & is_store;
   assign exc_badvaddr = addr_err ? mem_m_vaddr : 32'h0;

   // FSM next state and stall
   always_comb begin
      state_d   = state_q;
      stall_req = 1'b0;
      latch     = 1'b0;
      capture   = 1'b0;
      case (state_q)
         StIdle: begin
            if (access_ok) begin
               latch     = 1'b1;
               stall_req = 1'b1;
               state_d   = StReq;
            end
         end
         StReq: begin
            stall_req = 1'b1;
            if (dbus_ack) begin
               capture = 1'b1;
               state_d = flush ? StIdle : StDone;
            end else if (flush) begin
               state_d = StAbort;
            end
         end
         StDone:  state_d = StIdle;
         // Bus cannot be cancelled; wait out the ack and drop the data
         StAbort: begin
            stall_req = 1'b1;
            if (dbus_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         addr_q  <= 32'h0;
         wen_q   <= 4'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (latch) begin
            addr_q  <= {mem_m_vaddr[31:2], 2'b00};
            wen_q   <= mem_m_wen;
            wdata_q <= mem_m_wdata;
         end
         if (capture) rdata_q <= dbus_rdata;
      end
   end

   assign dbus_req   = (state_q == StReq) | (state_q == StAbort);
   assign dbus_addr  = addr_q;
   assign dbus_wen   = wen_q;
   assign dbus_wdata = wdata_q;

   // Load alignment (little-endian)
   always_comb begin
      byte_sel  = rdata_q[{b, 3'b000} +: 8];
      half_sel  = b[1] ? rdata_q[31:16] : rdata_q[15:0];
      load_data = rdata_q;
      case (mem_aluop)
         ALU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
         ALU_LBU: load_data = {24'h0, byte_sel};
         ALU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
         ALU_LHU: load_data = {16'h0, half_sel};
`ifdef MEM_LWLR_EN
         ALU_LWL: begin
            case (b)
               2'd0:    load_data = {rdata_q[7:0],  mem_opr2[23:0]};
               2'd1:    load_data = {rdata_q[15:0], mem_opr2[15:0]};
               2'd2:    load_data = {rdata_q[23:0], mem_opr2[7:0]};
               default: load_data = rdata_q;
            endcase
         end
         ALU_LWR: begin
            case (b)
               2'd0:    load_data = rdata_q;
               2'd1:    load_data = {mem_opr2[31:24], rdata_q[31:8]};
               2'd2:    load_data = {mem_opr2[31:16], rdata_q[31:16]};
               default: load_data = {mem_opr2[31:8],  rdata_q[31:24]};
            endcase
         end
`endif
         default: load_data = rdata_q;
      endcase
   end

   // Loads write back only in DONE; aborted or flushed work never writes
   assign wb_pc     = mem_pc;
   assign wb_wraddr = mem_wraddr;
   assign wb_wrdata = (is_load & ~op_off) ? load_data : mem_alures;
   assign wb_wreg   = mem_wreg & ~flush & ~addr_err & ~is_store & ~op_off &
                      (state_q != StAbort) &
                      (~(is_load & mem_m_en) | (state_q == StDone));

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam logic [7:0] ALU_NOP = 8'h00;
   localparam logic [7:0] ALU_LB  = 8'h10, ALU_LBU = 8'h11, ALU_LH  = 8'h12, ALU_LHU = 8'h13;
   localparam logic [7:0] ALU_LW  = 8'h14, ALU_LWL = 8'h15, ALU_LWR = 8'h16;
   localparam logic [7:0] ALU_SB  = 8'h18, ALU_SH  = 8'h19, ALU_SW  = 8'h1A;
   localparam logic [7:0] ALU_SWL = 8'h1B, ALU_SWR = 8'h1C;
`ifdef MEM_LWLR_EN
   localparam bit LWLR = 1'b1;
`else
   localparam bit LWLR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush, mem_wreg, mem_m_en, dbus_ack;
   logic [31:0] mem_pc, mem_alures, mem_opr2, mem_m_vaddr, mem_m_wdata, dbus_rdata;
   logic [7:0]  mem_aluop;
   logic [4:0]  mem_wraddr;
   logic [3:0]  mem_m_wen;
   logic        dbus_req, stall_req, exc_adel, exc_ades, wb_wreg;
   logic [31:0] dbus_addr, dbus_wdata, exc_badvaddr, wb_pc, wb_wrdata;
   logic [3:0]  dbus_wen;
   logic [4:0]  wb_wraddr;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .mem_pc(mem_pc), .mem_aluop(mem_aluop),
      .mem_alures(mem_alures), .mem_opr2(mem_opr2), .mem_wreg(mem_wreg),
      .mem_wraddr(mem_wraddr), .mem_m_en(mem_m_en), .mem_m_wen(mem_m_wen),
      .mem_m_vaddr(mem_m_vaddr), .mem_m_wdata(mem_m_wdata), .dbus_req(dbus_req),
      .dbus_addr(dbus_addr), .dbus_wen(dbus_wen), .dbus_wdata(dbus_wdata),
      .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack), .stall_req(stall_req),
      .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr),
      .wb_pc(wb_pc), .wb_wreg(wb_wreg), .wb_wraddr(wb_wraddr), .wb_wrdata(wb_wrdata)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int stall_cnt = 0;

   // Expected outputs for the current cycle
   logic        chk_en = 1'b0;
   logic        e_stall, e_req, e_adel, e_ades, e_wreg, e_data_chk;
   logic [31:0] e_addr, e_wdata, e_bad, e_wrdata, e_pc;
   logic [3:0]  e_wen;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk32(name, {31'h0, act}, {31'h0, exp});
   endtask

   function automatic bit is_ld(input logic [7:0] op);
      return op inside {ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_LWL, ALU_LWR};
   endfunction
   function automatic bit is_st(input logic [7:0] op);
      return op inside {ALU_SB, ALU_SH, ALU_SW, ALU_SWL, ALU_SWR};
   endfunction
   function automatic bit is_lr(input logic [7:0] op);
      return op inside {ALU_LWL, ALU_LWR, ALU_SWL, ALU_SWR};
   endfunction
   function automatic bit misal(input logic [7:0] op, input logic [31:0] va);
      return ((op inside {ALU_LH, ALU_LHU, ALU_SH}) && va[0]) ||
             ((op inside {ALU_LW, ALU_SW}) && (va[1:0] != 2'b00));
   endfunction

   // Reference load result from the architectural rules
   function automatic logic [31:0] ld_model(input logic [7:0] op, input logic [31:0] va,
                                            input logic [31:0] rd, input logic [31:0] rt);
      int          bi;
      int          sh;
      logic [31:0] s;
      bi = int'(va[1:0]);
      case (op)
         ALU_LB:  begin s = rd >> (8 * bi); return {{24{s[7]}}, s[7:0]}; end
         ALU_LBU: begin s = rd >> (8 * bi); return {24'h0, s[7:0]}; end
         ALU_LH:  begin s = rd >> (16 * (bi / 2)); return {{16{s[15]}}, s[15:0]}; end
         ALU_LHU: begin s = rd >> (16 * (bi / 2)); return {16'h0, s[15:0]}; end
         ALU_LWL: begin sh = 8 * (3 - bi); return (rd << sh) | (rt & ((32'h1 << sh) - 32'h1)); end
         ALU_LWR: begin sh = 8 * bi; return (rd >> sh) | (rt & ~(32'hFFFF_FFFF >> sh)); end
         default: return rd;
      endcase
   endfunction

   // Compare process
   always @(negedge clk) begin
      if (chk_en) begin
         chk1("stall_req", stall_req, e_stall);
         chk1("dbus_req", dbus_req, e_req);
         chk1("exc_adel", exc_adel, e_adel);
         chk1("exc_ades", exc_ades, e_ades);
         chk1("wb_wreg", wb_wreg, e_wreg);
         chk32("wb_pc", wb_pc, e_pc);
         chk32("wb_wraddr", {27'h0, wb_wraddr}, 32'd9);
         if (e_req) begin
            chk32("dbus_addr", dbus_addr, e_addr);
            chk32("dbus_wen", {28'h0, dbus_wen}, {28'h0, e_wen});
            chk32("dbus_wdata", dbus_wdata, e_wdata);
         end
         if (e_adel || e_ades) chk32("exc_badvaddr", exc_badvaddr, e_bad);
         if (e_data_chk) chk32("wb_wrdata", wb_wrdata, e_wrdata);
         if (stall_req) stall_cnt++;
      end
   end

   task automatic drive_nop(input logic [31:0] pc, input logic [31:0] alures);
      mem_pc = pc; mem_aluop = ALU_NOP; mem_alures = alures; mem_opr2 = 32'h0;
      mem_wreg = 1'b1; mem_wraddr = 5'd9; mem_m_en = 1'b0; mem_m_wen = 4'h0;
      mem_m_vaddr = 32'h0; mem_m_wdata = 32'h0; flush = 1'b0; dbus_ack = 1'b0;
      e_stall = 1'b0; e_req = 1'b0; e_adel = 1'b0; e_ades = 1'b0; e_wreg = 1'b1;
      e_data_chk = 1'b1; e_wrdata = alures; e_pc = pc;
   endtask

   // One instruction through MEM. ack_at: REQ cycle (1-based) carrying ack;
   // flush_at: REQ cycle raising flush (0 = none).
   task automatic mem_op(input logic [7:0] op, input logic [31:0] va, input logic [31:0] wd,
                         input logic [3:0] wen, input logic [31:0] rt, input int ack_at,
                         input logic [31:0] rd, input int flush_at,
                         output logic [31:0] wb_seen, output logic [31:0] addr_seen);
      bit ld, st, en, err, ok, aborted;
      logic [31:0] pc;
      ld  = is_ld(op);
      st  = is_st(op);
      en  = !(is_lr(op) && !LWLR);
      err = en && misal(op, va);
      ok  = en && !err;
      pc  = 32'h0040_0000 + va;
      addr_seen = 32'h0;
      @(posedge clk); #1;
      mem_pc = pc; mem_aluop = op; mem_alures = 32'hA1A1_0000 ^ va; mem_opr2 = rt;
      mem_wreg = 1'b1; mem_wraddr = 5'd9; mem_m_en = 1'b1; mem_m_wen = wen;
      mem_m_vaddr = va; mem_m_wdata = wd; flush = 1'b0; dbus_ack = 1'b0;
      e_pc = pc; e_stall = ok; e_req = 1'b0; e_adel = err && ld; e_ades = err && st;
      e_bad = va; e_wreg = 1'b0; e_data_chk = st; e_wrdata = mem_alures;
      @(negedge clk);
      wb_seen = wb_wrdata;
      if (!ok) return;
      aborted = 1'b0;
      for (int i = 1; i <= ack_at; i++) begin
         @(posedge clk); #1;
         flush = (i == flush_at);
         if (i == flush_at) aborted = 1'b1;
         dbus_ack = (i == ack_at);
         dbus_rdata = (i == ack_at) ? rd : 32'h5A5A_5A5A;
         e_stall = 1'b1; e_req = 1'b1; e_addr = {va[31:2], 2'b00}; e_wen = wen;
         e_wdata = wd; e_wreg = 1'b0; e_data_chk = 1'b0; e_adel = 1'b0; e_ades = 1'b0;
         @(negedge clk);
         if (i == 1) addr_seen = dbus_addr;
      end
      @(posedge clk); #1;
      flush = 1'b0; dbus_ack = 1'b0;
      if (aborted) begin
         drive_nop(pc + 32'h4, 32'h0BAD_0BAD);
      end else begin
         e_stall = 1'b0; e_req = 1'b0; e_wreg = ld; e_data_chk = 1'b1;
         e_wrdata = ld ? ld_model(op, va, rd, rt) : mem_alures;
      end
      @(negedge clk);
      wb_seen = wb_wrdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] seen, aseen;
      drive_nop(32'h0, 32'h0);
      dbus_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_stall", stall_req, 1'b0);
      chk1("rst_dbus_req", dbus_req, 1'b0);
      chk32("rst_dbus_addr", dbus_addr, 32'h0);
      chk32("rst_dbus_wen", {28'h0, dbus_wen}, 32'h0);
      chk32("rst_dbus_wdata", dbus_wdata, 32'h0);
      chk1("rst_adel", exc_adel, 1'b0);
      chk1("rst_ades", exc_ades, 1'b0);
      rst = 1'b1;
      drive_nop(32'h100, 32'h1234_5678);
      chk_en = 1'b1;

      stall_cnt = 0;
      mem_op(ALU_LW, 32'h0000_1004, 32'h0, 4'b0000, 32'h0, 2, 32'hDEAD_BEEF, 0, seen, aseen);
      chk32("lw_data", seen, 32'hDEAD_BEEF);
      chk32("lw_addr", aseen, 32'h0000_1004);
      chk32("lw_stall_cycles", stall_cnt, 32'd3);

      mem_op(ALU_LB, 32'h0000_2003, 32'h0, 4'b0000, 32'h0, 1, 32'h80FF_FFFF, 0, seen, aseen);
      chk32("lb_data", seen, 32'hFFFF_FF80);
      mem_op(ALU_LBU, 32'h0000_2003, 32'h0, 4'b0000, 32'h0, 1, 32'h80FF_FFFF, 0, seen, aseen);
      chk32("lbu_data", seen, 32'h0000_0080);
      mem_op(ALU_LH, 32'h0000_2002, 32'h0, 4'b0000, 32'h0, 3, 32'h8001_1234, 0, seen, aseen);
      chk32("lh_data", seen, 32'hFFFF_8001);
      mem_op(ALU_LHU, 32'h0000_2000, 32'h0, 4'b0000, 32'h0, 1, 32'h8001_9234, 0, seen, aseen);
      chk32("lhu_data", seen, 32'h0000_9234);

      mem_op(ALU_LH, 32'h0000_3001, 32'h0, 4'b0000, 32'h0, 1, 32'h0, 0, seen, aseen);
      mem_op(ALU_SW, 32'h0000_3002, 32'h1, 4'b1111, 32'h0, 1, 32'h0, 0, seen, aseen);

      stall_cnt = 0;
      mem_op(ALU_SB, 32'h0000_4002, 32'h00AB_0000, 4'b0100, 32'h0, 1, 32'h0, 0, seen, aseen);
      chk32("sb_addr", aseen, 32'h0000_4000);
      chk32("sb_stall_cycles", stall_cnt, 32'd2);
      mem_op(ALU_SW, 32'h0000_4008, 32'hCAFE_F00D, 4'b1111, 32'h0, 2, 32'h0, 0, seen, aseen);

      // Flush in first REQ cycle, ack four cycles later
      mem_op(ALU_LW, 32'h0000_5000, 32'h0, 4'b0000, 32'h0, 5, 32'h1357_9BDF, 1, seen, aseen);
      chk32("abort_no_wb", seen, 32'h0BAD_0BAD);
      // Flush together with ack
      mem_op(ALU_LW, 32'h0000_5010, 32'h0, 4'b0000, 32'h0, 2, 32'h2468_ACE0, 2, seen, aseen);
      // Back-to-back access right after an abort
      mem_op(ALU_LW, 32'h0000_5020, 32'h0, 4'b0000, 32'h0, 1, 32'h0F0F_0F0F, 0, seen, aseen);
      chk32("post_abort_lw", seen, 32'h0F0F_0F0F);

      mem_op(ALU_LWL, 32'h0000_6001, 32'h0, 4'b0000, 32'h1122_3344, 1, 32'hAABB_CCDD, 0,
             seen, aseen);
      if (LWLR) chk32("lwl_data", seen, 32'hCCDD_3344);
      mem_op(ALU_LWR, 32'h0000_6002, 32'h0, 4'b0000, 32'h1122_3344, 1, 32'hAABB_CCDD, 0,
             seen, aseen);
      if (LWLR) chk32("lwr_data", seen, 32'h1122_AABB);
      mem_op(ALU_SWL, 32'h0000_6003, 32'h0000_00AA, 4'b0001, 32'h0, 1, 32'h0, 0, seen, aseen);

      // Reset in the middle of an access
      @(posedge clk); #1;
      chk_en = 1'b0;
      mem_aluop = ALU_LW; mem_m_en = 1'b1; mem_m_vaddr = 32'h0000_7000;
      @(posedge clk); #1;
      chk1("midrst_req_before", dbus_req, 1'b1);
      rst = 1'b0;
      #1;
      chk1("midrst_req_after", dbus_req, 1'b0);
      chk32("midrst_addr", dbus_addr, 32'h0);
      drive_nop(32'h200, 32'h7777_0000);
      @(posedge clk); #1;
      rst = 1'b1;
      chk_en = 1'b1;
      mem_op(ALU_LW, 32'h0000_7004, 32'h0, 4'b0000, 32'h0, 1, 32'h600D_600D, 0, seen, aseen);
      chk32("post_rst_lw", seen, 32'h600D_600D);

      @(posedge clk); #1;
      drive_nop(32'h300, 32'h0);
      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
